// File: rtl/proc_control_unit_if.sv
// Control-unit bus: start request and instruction in, datapath steering out.
// Macro PROC_CTRL_MVNZ_EN (see proc_control_unit) changes how GNZ is used.
// Ports (master = control unit, slave = datapath/sequencer side):
//   Run        start request, sampled only in T0
//   IR_in      9-bit instruction word (III XXX YYY)
//   GNZ        G register non-zero flag
//   Control    10-bit one-hot bus-mux select (bit 9-k = Rk, bit 1 = DIN, bit 0 = G)
//   Rin        register-file write enables, bit k = Rk
//   Ain/Gin    A and G register loads
//   IRin       IR load strobe
//   AddSub     ALU mode, 0 add / 1 sub
//   Done       pulse in the final cycle of an instruction
//   InstrCount instructions completed since reset
interface proc_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Run;
  logic [8:0]       IR_in;
  logic             GNZ;
  logic [9:0]       Control;
  logic [7:0]       Rin;
  logic             Ain;
  logic             Gin;
  logic             IRin;
  logic             AddSub;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Run, IR_in, GNZ,
    output Control, Rin, Ain, Gin, IRin, AddSub, Done, InstrCount
  );

  modport slave (
    output Run, IR_in, GNZ,
    input  Control, Rin, Ain, Gin, IRin, AddSub, Done, InstrCount
  );
endinterface

// File: rtl/proc_control_unit.sv
// Instruction-sequencing FSM for the simple 16-bit processor. Fetches one
// 9-bit instruction per Run request and steers the 10:1 bus mux, register
// loads and ALU mode over 2 (mv/mvi/illegal) or 4 (add/sub) cycles.
// Ports:
//   Clock   rising-edge clock
//   Resetn  synchronous active-low reset; also forces all outputs to 0
//   bus     proc_control_unit_if.master (Run/IR_in/GNZ in, steering out)
// Optional feature: define PROC_CTRL_MVNZ_EN to make opcode 100 a
// conditional move (mvnz) on GNZ; otherwise opcode 100 is illegal.
module proc_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  proc_control_unit_if.master    bus
);

  localparam int unsigned SEL_W = 10;
  localparam int unsigned REG_N = 8;
  localparam int unsigned IR_W  = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(1);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t           state;
  logic [IR_W-1:0]  ir;
  logic [CNT_W-1:0] count;

  logic [2:0] opc;
  logic [2:0] rx;
  logic [2:0] ry;

  logic [SEL_W-1:0] control_c;
  logic [REG_N-1:0] rin_c;
  logic             ain_c;
  logic             gin_c;
  logic             irin_c;
  logic             addsub_c;
  logic             done_c;

  assign opc = ir[8:6];
  assign rx  = ir[5:3];
  assign ry  = ir[2:0];

  // Bus-mux select for register Rk lives at bit 9-k.
  function automatic logic [SEL_W-1:0] sel_reg(input logic [2:0] k);
    sel_reg = SEL_W'(SEL_W'(512) >> k);
  endfunction

  function automatic logic [REG_N-1:0] wen_reg(input logic [2:0] k);
    wen_reg = REG_N'(REG_N'(1) << k);
  endfunction

  // State, instruction register and completed-instruction counter.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
      count <= '0;
    end else begin
      unique case (state)
        T0: begin
          if (bus.Run) begin
            ir    <= bus.IR_in;
            state <= T1;
          end
        end
        T1: begin
          if (opc == OP_ADD || opc == OP_SUB) begin
            state <= T2;
          end else begin
            state <= T0;
          end
        end
        T2:      state <= T3;
        default: state <= T0;
      endcase
      if (done_c) begin
        count <= CNT_W'(count + CNT_W'(1));
      end
    end
  end

  // Per-state steering decode from state and the captured instruction.
  always_comb begin
    control_c = '0;
    rin_c     = '0;
    ain_c     = 1'b0;
    gin_c     = 1'b0;
    irin_c    = 1'b0;
    addsub_c  = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      T0: begin
        if (bus.Run) begin
          irin_c    = 1'b1;
          control_c = SEL_DIN;
        end
      end
      T1: begin
        unique case (opc)
          OP_MV: begin
            control_c = sel_reg(ry);
            rin_c     = wen_reg(rx);
            done_c    = 1'b1;
          end
          OP_MVI: begin
            control_c = SEL_DIN;
            rin_c     = wen_reg(rx);
            done_c    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            control_c = sel_reg(rx);
            ain_c     = 1'b1;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            done_c = 1'b1;
            if (bus.GNZ) begin
              control_c = sel_reg(ry);
              rin_c     = wen_reg(rx);
            end
          end
`endif
          default: begin
            done_c = 1'b1;
          end
        endcase
      end
      T2: begin
        control_c = sel_reg(ry);
        gin_c     = 1'b1;
        addsub_c  = (opc == OP_SUB);
      end
      default: begin
        control_c = SEL_G;
        rin_c     = wen_reg(rx);
        addsub_c  = (opc == OP_SUB);
        done_c    = 1'b1;
      end
    endcase
  end

`ifndef PROC_CTRL_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = bus.GNZ;
`endif

  // Reset forces every output low so an aborted instruction writes nothing.
  assign bus.Control    = Resetn ? control_c : '0;
  assign bus.Rin        = Resetn ? rin_c     : '0;
  assign bus.Ain        = Resetn & ain_c;
  assign bus.Gin        = Resetn & gin_c;
  assign bus.IRin       = Resetn & irin_c;
  assign bus.AddSub     = Resetn & addsub_c;
  assign bus.Done       = Resetn & done_c;
  assign bus.InstrCount = Resetn ? count : '0;

endmodule
